muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_watchdog.sv | 27 ++
 rtl/muldiv_ctrl.sv | 105 ++++++++++
 tb/tb_muldiv_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide controller: state encodings,
// watchdog limit and HI/LO source select values. Optional MULDIV_TIMEOUT_EN adds a RUN watchdog.
package muldiv_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MULT_RUN = 3'd1,
        DIV_RUN  = 3'd2,
        WRITE    = 3'd3,
        DIV0     = 3'd4
    } state_t;

    localparam int   TIMEOUT_WIDTH = 6;
    localparam int   TIMEOUT_LIMIT = 63;
    localparam logic HILO_SEL_DIV  = 1'b0;
    localparam logic HILO_SEL_MULT = 1'b1;

    function automatic logic is_run(input state_t s);
        return (s == MULT_RUN) || (s == DIV_RUN);
    endfunction

endpackage

// File: rtl/muldiv_watchdog.sv
// RUN-phase cycle counter for muldiv_ctrl; only instantiated when MULDIV_TIMEOUT_EN is defined.
module muldiv_watchdog
    import muldiv_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    logic [TIMEOUT_WIDTH-1:0] count;

    // Cleared on RUN entry, so the first RUN cycle sees 0 and the 64th sees the limit.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == TIMEOUT_WIDTH'(TIMEOUT_LIMIT));

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencing controller: launches the Mult/Div units and writes HI/LO.
// Defining MULDIV_TIMEOUT_EN adds a watchdog that abandons a RUN after 64 cycles without done.
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       start_mult,
    input  logic       start_div,
    input  logic       read_hilo,
    input  logic       mult_done,
    input  logic       div_done,
    input  logic       div_zero,
    output logic       mult_start,
    output logic       div_start,
    output logic       hi_sel,
    output logic       lo_sel,
    output logic       write_hi,
    output logic       write_lo,
    output logic       busy,
    output logic       stall,
    output logic       div0_exc,
    output logic       timeout_exc,
    output logic [2:0] state_out
);

    state_t state;
    state_t next_state;
    logic   timed_out;

`ifdef MULDIV_TIMEOUT_EN
    logic wd_expired;

    muldiv_watchdog u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   ((state == IDLE) && is_run(next_state)),
        .run     (is_run(state)),
        .expired (wd_expired)
    );

    assign timed_out = wd_expired;
`else
    assign timed_out = 1'b0;
`endif

    // A zero divisor overrides a simultaneous div_done; done always beats the watchdog.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_mult)     next_state = MULT_RUN;
                else if (start_div) next_state = DIV_RUN;
            end
            MULT_RUN: begin
                if (mult_done)      next_state = WRITE;
                else if (timed_out) next_state = IDLE;
            end
            DIV_RUN: begin
                if (div_zero)       next_state = DIV0;
                else if (div_done)  next_state = WRITE;
                else if (timed_out) next_state = IDLE;
            end
            default:                next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            mult_start  <= 1'b0;
            div_start   <= 1'b0;
            hi_sel      <= 1'b0;
            lo_sel      <= 1'b0;
            write_hi    <= 1'b0;
            write_lo    <= 1'b0;
            busy        <= 1'b0;
            stall       <= 1'b0;
            div0_exc    <= 1'b0;
            timeout_exc <= 1'b0;
        end else begin
            state      <= next_state;
            mult_start <= (state == IDLE) && (next_state == MULT_RUN);
            div_start  <= (state == IDLE) && (next_state == DIV_RUN);
            write_hi   <= (next_state == WRITE);
            write_lo   <= (next_state == WRITE);
            // Selects hold their last value between writes.
            if (next_state == WRITE) begin
                hi_sel <= (state == MULT_RUN) ? HILO_SEL_MULT : HILO_SEL_DIV;
                lo_sel <= (state == MULT_RUN) ? HILO_SEL_MULT : HILO_SEL_DIV;
            end
            busy     <= (next_state != IDLE);
            stall    <= (next_state != IDLE) && (read_hilo || start_mult || start_div);
            div0_exc <= (next_state == DIV0);
`ifdef MULDIV_TIMEOUT_EN
            timeout_exc <= is_run(state) && (next_state == IDLE);
`else
            timeout_exc <= 1'b0;
`endif
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed scenarios plus random traffic against an
// operation-level reference model. Honours MULDIV_TIMEOUT_EN the same way as the design.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

`ifdef MULDIV_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start_mult = 1'b0;
    logic       start_div = 1'b0;
    logic       read_hilo = 1'b0;
    logic       mult_done = 1'b0;
    logic       div_done = 1'b0;
    logic       div_zero = 1'b0;
    logic       mult_start, div_start, hi_sel, lo_sel, write_hi, write_lo;
    logic       busy, stall, div0_exc, timeout_exc;
    logic [2:0] state_out;

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    // Reference model: operation in flight (0 none, 1 mult, 2 div), finishing action
    // (0 none, 1 write from mult, 2 write from div, 3 divide-by-zero) and RUN cycles elapsed.
    int         m_op = 0;
    int         m_fin = 0;
    int         m_cnt = 0;
    logic       e_ms, e_ds, e_hs, e_ls, e_wh, e_wl, e_busy, e_stall, e_d0, e_to;
    logic [2:0] e_state;

    always #5 clock = ~clock;

    muldiv_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .start_mult  (start_mult),
        .start_div   (start_div),
        .read_hilo   (read_hilo),
        .mult_done   (mult_done),
        .div_done    (div_done),
        .div_zero    (div_zero),
        .mult_start  (mult_start),
        .div_start   (div_start),
        .hi_sel      (hi_sel),
        .lo_sel      (lo_sel),
        .write_hi    (write_hi),
        .write_lo    (write_lo),
        .busy        (busy),
        .stall       (stall),
        .div0_exc    (div0_exc),
        .timeout_exc (timeout_exc),
        .state_out   (state_out)
    );

    task automatic modelStep();
        bit done_seen;
        e_ms = 1'b0; e_ds = 1'b0; e_wh = 1'b0; e_wl = 1'b0; e_d0 = 1'b0; e_to = 1'b0;
        if (reset) begin
            m_op = 0; m_fin = 0; m_cnt = 0;
            e_hs = 1'b0; e_ls = 1'b0;
        end else if (m_fin != 0) begin
            m_fin = 0;
        end else if (m_op == 0) begin
            if (start_mult) begin
                m_op = 1; m_cnt = 0; e_ms = 1'b1;
            end else if (start_div) begin
                m_op = 2; m_cnt = 0; e_ds = 1'b1;
            end
        end else begin
            done_seen = (m_op == 1) ? mult_done : (div_done || div_zero);
            if (done_seen) begin
                m_fin = (m_op == 1) ? 1 : (div_zero ? 3 : 2);
                m_op = 0;
            end else if (TO_EN && m_cnt == 63) begin
                m_op = 0; e_to = 1'b1;
            end else begin
                m_cnt++;
            end
        end
        if (m_fin == 1 || m_fin == 2) begin
            e_wh = 1'b1; e_wl = 1'b1;
            e_hs = (m_fin == 1); e_ls = (m_fin == 1);
        end
        e_d0    = (m_fin == 3);
        e_busy  = (m_op != 0) || (m_fin != 0);
        e_stall = e_busy && (read_hilo || start_mult || start_div);
        if (m_fin == 1 || m_fin == 2) e_state = WRITE;
        else if (m_fin == 3)          e_state = DIV0;
        else if (m_op == 1)           e_state = MULT_RUN;
        else if (m_op == 2)           e_state = DIV_RUN;
        else                          e_state = IDLE;
    endtask

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic checkOutput();
        check("mult_start",  {2'b00, mult_start},  {2'b00, e_ms});
        check("div_start",   {2'b00, div_start},   {2'b00, e_ds});
        check("hi_sel",      {2'b00, hi_sel},      {2'b00, e_hs});
        check("lo_sel",      {2'b00, lo_sel},      {2'b00, e_ls});
        check("write_hi",    {2'b00, write_hi},    {2'b00, e_wh});
        check("write_lo",    {2'b00, write_lo},    {2'b00, e_wl});
        check("busy",        {2'b00, busy},        {2'b00, e_busy});
        check("stall",       {2'b00, stall},       {2'b00, e_stall});
        check("div0_exc",    {2'b00, div0_exc},    {2'b00, e_d0});
        check("timeout_exc", {2'b00, timeout_exc}, {2'b00, e_to});
        check("state_out",   state_out,            e_state);
    endtask

    // Drive one cycle's inputs, let the edge sample them, then compare #1 later.
    task automatic applyStimulus(input logic rst, input logic sm, input logic sd, input logic rh,
                                 input logic md, input logic dd, input logic dz);
        reset = rst; start_mult = sm; start_div = sd; read_hilo = rh;
        mult_done = md; div_done = dd; div_zero = dz;
        @(posedge clock);
        modelStep();
        cyc++;
        #1;
        checkOutput();
    endtask

    initial begin
        $display("[TB] muldiv_ctrl bench start (timeout enabled = %0d)", TO_EN);

        // Cycles 0-1: reset
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        check("reset_state", state_out, 3'd0);
        check("reset_busy", {2'b00, busy}, 3'd0);

        // Multiply: start at cycle 2, done at cycle 35
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        check("mult_start_c3", {2'b00, mult_start}, 3'd1);
        for (int i = 3; i <= 34; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        check("write_hi_c36", {2'b00, write_hi}, 3'd1);
        check("write_lo_c36", {2'b00, write_lo}, 3'd1);
        check("hi_sel_c36", {2'b00, hi_sel}, 3'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        check("busy_c37", {2'b00, busy}, 3'd0);
        check("hi_sel_hold", {2'b00, hi_sel}, 3'd1);

        // Divide by zero reported together with done on the first DIV_RUN cycle
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        check("div_start", {2'b00, div_start}, 3'd1);
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        check("div0_exc", {2'b00, div0_exc}, 3'd1);
        check("div0_no_write", {2'b00, write_hi}, 3'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        check("div0_idle", state_out, 3'd0);

        // Simultaneous starts: multiply wins, div_done in MULT_RUN is ignored
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        check("both_mult_start", {2'b00, mult_start}, 3'd1);
        check("both_no_div_start", {2'b00, div_start}, 3'd0);
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        check("div_done_ignored", {2'b00, busy}, 3'd1);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // read_hilo held through a divide, then in IDLE
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 1, 0, 0, 0);
            check("stall_div_run", {2'b00, stall}, 3'd1);
        end
        applyStimulus(0, 0, 0, 1, 0, 1, 0);
        check("div_write_sel", {2'b00, lo_sel}, 3'd0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        check("stall_idle", {2'b00, stall}, 3'd0);

        // Reset mid-multiply, then a late mult_done
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        check("reset_mid_idle", state_out, 3'd0);
        check("reset_mid_no_write", {2'b00, write_hi}, 3'd0);

        // Divide with no done for 70 cycles
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 70; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0);
`ifdef MULDIV_TIMEOUT_EN
            if (i == 64) begin
                check("timeout_exc_64", {2'b00, timeout_exc}, 3'd1);
                check("timeout_busy", {2'b00, busy}, 3'd0);
                check("timeout_no_write", {2'b00, write_hi}, 3'd0);
            end
`endif
        end
`ifndef MULDIV_TIMEOUT_EN
        check("no_timeout_busy", {2'b00, busy}, 3'd1);
`endif
        applyStimulus(1, 0, 0, 0, 0, 0, 0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 63) == 0,
                          $urandom_range(0, 7) == 0,
                          $urandom_range(0, 7) == 0,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 19) == 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
